rls_sequencer: RTL and testbench
================================

# rls_sequencer

Control sequencer that drives the RLS datapath's `load`, `seleccion`, `en1` and `shift` strobes and captures its `s` result. It is the initiator side of the RLS control interface. It replaces hand-timed strobes with a parameterised FSM: load pulse, select settle window, shift window, then result capture. It sits between the system controller (`start`/`done`) and the RLS datapath.

## Interface
- `WIDTH`, 32: width of the `s` result bus.
- `SETTLE_CYCLES`, 9: cycles `seleccion`=1 before shifting starts. 0 is legal.
- `SHIFT_CYCLES`, 32: cycles `en1`=`shift`=1. Minimum 1.
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request one sequence; sampled only in IDLE.
- `s_in`  in  WIDTH  RLS `s` output; sampled in CAPTURE.
- `load`  out  1  RLS load strobe.
- `seleccion`  out  1  RLS input select.
- `en1`  out  1  RLS enable.
- `shift`  out  1  RLS shift strobe.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when `result` is updated.
- `result`  out  WIDTH  captured `s_in`.
- `result_valid`  out  1  `result` holds data from a completed sequence.

## Operation
- All outputs are registered. The state and outputs of the FSM change only on `clk` edges.
- Reset values: all outputs 0, `result`=0, `result_valid`=0, state IDLE, counter 0.
- States and transitions:
  - IDLE: all strobes 0. `start`=1 → LOAD and clear `result_valid`.
  - LOAD: `load`=1 for 1 cycle → GAP.
  - GAP: all strobes 0 for 1 cycle. Then → SETTLE, or → SHIFT if `SETTLE_CYCLES`=0.
  - SETTLE: `seleccion`=1 for exactly `SETTLE_CYCLES` cycles → SHIFT.
  - SHIFT: `seleccion`=`en1`=`shift`=1 for exactly `SHIFT_CYCLES` cycles → CAPTURE.
  - CAPTURE: `seleccion`=1, `en1`=`shift`=0. Latch `s_in` into `result`, set `result_valid`=1, pulse `done`=1 → IDLE.
- A single down-counter of width clog2(max(SETTLE_CYCLES,SHIFT_CYCLES)+1) is loaded on each state entry.
- `start` outside IDLE is ignored, not queued.
- `start` held high continuously in IDLE launches back-to-back sequences.
- `reset` mid-sequence: on the next edge, go to IDLE with all outputs at reset values. This includes forcing `result_valid`=0.
- `result` is stable from CAPTURE until the next CAPTURE or reset.

## Timing
- Let `start`=1 be sampled at edge k in IDLE. With defaults:
  - `load`=1 in cycle k+1.
  - GAP in cycle k+2.
  - `seleccion`=1 from k+3 through k+44.
  - `en1`/`shift`=1 from k+12 through k+43, which is 32 cycles.
  - `done`=1 and `result` valid in cycle k+44.
  - IDLE at k+45.
- General latency from `start` to `done` = 3 + SETTLE_CYCLES + SHIFT_CYCLES cycles.
- `s_in` is sampled at the edge that ends CAPTURE. This is the first edge after the last shift.
- `busy` is high from k+1 through k+44 inclusive.

## Test plan
- Reset: hold `reset`=1 for 3 cycles with `start`=1 → all outputs 0 and state IDLE. The first `load` appears 1 cycle after `reset` falls.
- Nominal run (defaults), `start` pulse at cycle 0, `s_in`=32'h1234_5678 → check:
  - `load` only at cycle 1.
  - `seleccion` rises at cycle 3.
  - `shift`/`en1` high for exactly cycles 12–43.
  - `done`=1 at cycle 44 only, with `result`=32'h1234_5678 and `result_valid`=1.
- Ignored start: pulse `start` at cycles 0 and 20 → exactly one `load` pulse and one `done` at cycle 44.
- Reset mid-SHIFT: assert `reset` at cycle 25 → all strobes 0 at cycle 26, `result_valid`=0, and no `done`.
- Back-to-back: hold `start`=1 → `done` at cycles 44 and 89 with `load` at cycles 1 and 46. `result_valid` drops at cycle 46 and re-rises at cycle 89.
- Edge parameters: `SETTLE_CYCLES`=0, `SHIFT_CYCLES`=1 → `load` at cycle 1, `shift` at cycle 3 only, `done` at cycle 4.

Source files
------------

// File: rtl/rls_sequencer.sv
// Control sequencer for the RLS datapath: load pulse, select settle window,
// shift window, then capture of the datapath's s output.
module rls_sequencer #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 9,
    parameter int SHIFT_CYCLES  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] s_in,
    output logic             load,
    output logic             seleccion,
    output logic             en1,
    output logic             shift,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             result_valid
);

    localparam int MAX_CYCLES = (SETTLE_CYCLES > SHIFT_CYCLES) ? SETTLE_CYCLES : SHIFT_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES < 1) ? 1 : $clog2(MAX_CYCLES + 1);

    // The counter runs N-1 down to 0, so a window of N cycles loads N-1.
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] SHIFT_LOAD  = CNT_W'((SHIFT_CYCLES > 0) ? SHIFT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_GAP,
        ST_SETTLE,
        ST_SHIFT,
        ST_CAPTURE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Outputs are set on the edge that enters a state, so each strobe is
    // aligned exactly with the state it belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            load         <= 1'b0;
            seleccion    <= 1'b0;
            en1          <= 1'b0;
            shift        <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            load <= 1'b0;
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state        <= ST_LOAD;
                        cnt          <= '0;
                        load         <= 1'b1;
                        busy         <= 1'b1;
                        result_valid <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    state <= ST_GAP;
                    cnt   <= '0;
                end
                ST_GAP: begin
                    seleccion <= 1'b1;
                    if (SETTLE_CYCLES == 0) begin
                        state <= ST_SHIFT;
                        cnt   <= SHIFT_LOAD;
                        en1   <= 1'b1;
                        shift <= 1'b1;
                    end else begin
                        state <= ST_SETTLE;
                        cnt   <= SETTLE_LOAD;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == '0) begin
                        state <= ST_SHIFT;
                        cnt   <= SHIFT_LOAD;
                        en1   <= 1'b1;
                        shift <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_SHIFT: begin
                    if (cnt == '0) begin
                        // s_in is taken on the edge that closes the last shift cycle.
                        state        <= ST_CAPTURE;
                        cnt          <= '0;
                        en1          <= 1'b0;
                        shift        <= 1'b0;
                        result       <= s_in;
                        result_valid <= 1'b1;
                        done         <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    state     <= ST_IDLE;
                    cnt       <= '0;
                    seleccion <= 1'b0;
                    busy      <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    cnt       <= '0;
                    seleccion <= 1'b0;
                    en1       <= 1'b0;
                    shift     <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rls_sequencer.sv
// Bench for rls_sequencer: default instance plus a SETTLE=0/SHIFT=1 instance,
// both compared every cycle against a timeline model of the sequence.
module tb_rls_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] s_in;

    logic        load_a, sel_a, en1_a, shift_a, busy_a, done_a, rv_a;
    logic [31:0] result_a;
    logic        load_b, sel_b, en1_b, shift_b, busy_b, done_b, rv_b;
    logic [31:0] result_b;

    always #5 clk = ~clk;

    rls_sequencer #(.WIDTH(32), .SETTLE_CYCLES(9), .SHIFT_CYCLES(32)) dut_nom (
        .clk(clk), .reset(reset), .start(start), .s_in(s_in),
        .load(load_a), .seleccion(sel_a), .en1(en1_a), .shift(shift_a),
        .busy(busy_a), .done(done_a), .result(result_a), .result_valid(rv_a)
    );

    rls_sequencer #(.WIDTH(32), .SETTLE_CYCLES(0), .SHIFT_CYCLES(1)) dut_edge (
        .clk(clk), .reset(reset), .start(start), .s_in(s_in),
        .load(load_b), .seleccion(sel_b), .en1(en1_b), .shift(shift_b),
        .busy(busy_b), .done(done_b), .result(result_b), .result_valid(rv_b)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Model: a sequence is a timeline relative to the cycle in which start
    // was accepted; off = cycle - base.
    int          p_settle [2] = '{9, 0};
    int          p_shift  [2] = '{32, 1};
    bit          m_act    [2] = '{1'b0, 1'b0};
    int          m_base   [2] = '{0, 0};
    logic [31:0] m_res    [2] = '{32'd0, 32'd0};
    bit          m_rv     [2] = '{1'b0, 1'b0};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, act, exp);
        end
    endtask

    function automatic int seq_len(input int i);
        return 3 + p_settle[i] + p_shift[i];
    endfunction

    function automatic bit idle_in(input int i, input int c);
        return !m_act[i] || (c - m_base[i]) > seq_len(i);
    endfunction

    task automatic model_edge(input int i, input bit r, input bit st, input logic [31:0] sv);
        if (r) begin
            m_act[i] = 1'b0;
            m_res[i] = '0;
            m_rv[i]  = 1'b0;
        end else begin
            if (idle_in(i, cyc - 1) && st) begin
                m_act[i]  = 1'b1;
                m_base[i] = cyc - 1;
                m_rv[i]   = 1'b0;
            end
            if (m_act[i] && (cyc - m_base[i]) == seq_len(i)) begin
                m_res[i] = sv;
                m_rv[i]  = 1'b1;
            end
        end
    endtask

    task automatic check_inst(input int i, input string nm,
                              input logic ld, input logic sl, input logic e1, input logic sh,
                              input logic bz, input logic dn, input logic [31:0] rs, input logic rv);
        int  off;
        int  len;
        bit  a;
        off = cyc - m_base[i];
        len = seq_len(i);
        a   = m_act[i];
        chk({nm, ".load"},         32'(ld), 32'(a && off == 1));
        chk({nm, ".seleccion"},    32'(sl), 32'(a && off >= 3 && off <= len));
        chk({nm, ".en1"},          32'(e1), 32'(a && off >= 3 + p_settle[i] && off <= len - 1));
        chk({nm, ".shift"},        32'(sh), 32'(a && off >= 3 + p_settle[i] && off <= len - 1));
        chk({nm, ".busy"},         32'(bz), 32'(a && off >= 1 && off <= len));
        chk({nm, ".done"},         32'(dn), 32'(a && off == len));
        chk({nm, ".result"},       rs,      m_res[i]);
        chk({nm, ".result_valid"}, 32'(rv), 32'(m_rv[i]));
    endtask

    // Inputs present now belong to the current cycle; advance one edge,
    // update the model with them, then compare shortly after the edge.
    task automatic tick();
        bit          pr;
        bit          ps;
        logic [31:0] pv;
        pr = reset;
        ps = start;
        pv = s_in;
        @(posedge clk);
        cyc++;
        model_edge(0, pr, ps, pv);
        model_edge(1, pr, ps, pv);
        #1;
        check_inst(0, "nom",  load_a, sel_a, en1_a, shift_a, busy_a, done_a, result_a, rv_a);
        check_inst(1, "edge", load_b, sel_b, en1_b, shift_b, busy_b, done_b, result_b, rv_b);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b1;
        s_in  = '0;
        repeat (3) tick();

        // start already high as reset falls
        reset = 1'b0;
        tick();
        start = 1'b0;
        repeat (50) tick();

        // nominal run
        s_in  = 32'h1234_5678;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (50) tick();

        // second start during the sequence is ignored
        s_in  = 32'hCAFE_0001;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (30) tick();

        // reset in the middle of the shift window
        s_in  = 32'hDEAD_BEEF;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (24) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (30) tick();

        // start held high: back-to-back sequences
        s_in  = 32'h0BAD_F00D;
        start = 1'b1;
        repeat (100) tick();
        start = 1'b0;
        repeat (50) tick();

        // randomized traffic with changing s_in and occasional resets
        repeat (800) begin
            start = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 99) == 0);
            s_in  = $urandom;
            tick();
        end
        reset = 1'b0;
        start = 1'b0;
        repeat (50) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
